// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: debug-stream FSM encoding, perf counter width and stream sizing.
package mips_pkg;

    typedef enum logic [1:0] {
        DBG_IDLE,
        DBG_CAPTURE,
        DBG_SEND
    } dbg_state_t;

    localparam int unsigned PERF_CNT_W = 16;

    function automatic int unsigned stage_bytes(input int unsigned data_w);
        return (data_w + 7) / 8;
    endfunction

    // Data bytes for every stage, one o_valid byte, then optional stall/flush counters.
    function automatic int unsigned stream_bytes(input int unsigned num_stages,
                                                 input int unsigned data_w,
                                                 input bit          perf_en);
        return num_stages * stage_bytes(data_w) + 1
               + (perf_en ? num_stages * 2 * (PERF_CNT_W / 8) : 0);
    endfunction

endpackage

// File: rtl/pipe_dbg_serializer.sv
// Snapshot capture and byte-wise stream of the pipeline registers for the UART debugger.
// With PIPE_CHAIN_PERF_EN defined the stall/flush counters follow the o_valid byte.
module pipe_dbg_serializer
    import mips_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned DATA_W     = 129
) (
    input  logic                           clk_to_use,
    input  logic                           i_rst,
    input  logic [NUM_STAGES*DATA_W-1:0]   pipe_data,
    input  logic [NUM_STAGES-1:0]          pipe_valid,
`ifdef PIPE_CHAIN_PERF_EN
    input  logic [NUM_STAGES*PERF_CNT_W-1:0] stall_cnt,
    input  logic [NUM_STAGES*PERF_CNT_W-1:0] flush_cnt,
`endif
    input  logic                           dbg_req,
    input  logic                           dbg_ready,
    output logic [7:0]                     dbg_byte,
    output logic                           dbg_valid,
    output logic                           dbg_busy
);

    localparam int unsigned SB = stage_bytes(DATA_W);
`ifdef PIPE_CHAIN_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int unsigned TOTAL = stream_bytes(NUM_STAGES, DATA_W, PERF);
    // Equals $clog2(NUM_STAGES*SB+1) without counters; widened when counter bytes are appended.
    localparam int unsigned BYTES_W = $clog2(TOTAL);
    localparam logic [BYTES_W-1:0] LAST = BYTES_W'(TOTAL - 1);

    dbg_state_t           state;
    logic [BYTES_W-1:0]   idx;
    logic [TOTAL*8-1:0]   image;
    logic [TOTAL*8-1:0]   snap;

    always_comb begin
        image = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            image[k*SB*8 +: DATA_W] = pipe_data[k*DATA_W +: DATA_W];
        end
        image[NUM_STAGES*SB*8 +: 8] = 8'(pipe_valid);
`ifdef PIPE_CHAIN_PERF_EN
        for (int k = 0; k < NUM_STAGES; k++) begin
            image[(NUM_STAGES*SB+1)*8 + k*PERF_CNT_W +: PERF_CNT_W] =
                stall_cnt[k*PERF_CNT_W +: PERF_CNT_W];
            image[(NUM_STAGES*SB+1)*8 + (NUM_STAGES+k)*PERF_CNT_W +: PERF_CNT_W] =
                flush_cnt[k*PERF_CNT_W +: PERF_CNT_W];
        end
`endif
    end

    always_ff @(posedge clk_to_use or posedge i_rst) begin
        if (i_rst) begin
            state     <= DBG_IDLE;
            idx       <= '0;
            snap      <= '0;
            dbg_byte  <= '0;
            dbg_valid <= 1'b0;
            dbg_busy  <= 1'b0;
        end else begin
            unique case (state)
                DBG_IDLE: begin
                    if (dbg_req) begin
                        state    <= DBG_CAPTURE;
                        dbg_busy <= 1'b1;
                    end
                end
                DBG_CAPTURE: begin
                    snap      <= image;
                    idx       <= '0;
                    dbg_byte  <= image[7:0];
                    dbg_valid <= 1'b1;
                    state     <= DBG_SEND;
                end
                DBG_SEND: begin
                    if (dbg_ready) begin
                        if (idx == LAST) begin
                            state     <= DBG_IDLE;
                            dbg_valid <= 1'b0;
                            dbg_busy  <= 1'b0;
                            dbg_byte  <= '0;
                        end else begin
                            idx      <= idx + 1'b1;
                            dbg_byte <= snap[(32'(idx) + 32'd1)*8 +: 8];
                        end
                    end
                end
                default: state <= DBG_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Chain of pipeline registers with stall, bubble, flush and debug freeze plus a snapshot streamer.
// Define PIPE_CHAIN_PERF_EN to add per-stage saturating stall/flush counters to the stream.
module pipe_reg_chain
    import mips_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned DATA_W     = 129
) (
    input  logic                         clk_to_use,
    input  logic                         i_rst,
    input  logic [NUM_STAGES*DATA_W-1:0] i_data,
    input  logic [NUM_STAGES-1:0]        i_stall,
    input  logic [NUM_STAGES-1:0]        i_flush,
    input  logic                         i_freeze,
    output logic [NUM_STAGES*DATA_W-1:0] o_data,
    output logic [NUM_STAGES-1:0]        o_valid,
    input  logic                         i_dbg_req,
    output logic [7:0]                   o_dbg_byte,
    output logic                         o_dbg_valid,
    input  logic                         i_dbg_ready,
    output logic                         o_dbg_busy
);

    logic [NUM_STAGES*DATA_W-1:0] data_q;
    logic [NUM_STAGES-1:0]        valid_q;
    logic [NUM_STAGES-1:0]        hold;
    logic [NUM_STAGES-1:0]        bubble;
    logic [NUM_STAGES-1:0]        prev_valid;

    // A stall anywhere downstream holds this register too.
    always_comb begin
        hold = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            hold[k] = i_freeze | (|(i_stall >> k));
        end
        bubble     = (hold << 1) & ~hold;
        prev_valid = NUM_STAGES'({valid_q, 1'b1});
    end

    always_ff @(posedge clk_to_use or posedge i_rst) begin
        if (i_rst) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (i_flush[k]) begin
                    data_q[k*DATA_W +: DATA_W] <= '0;
                    valid_q[k]                 <= 1'b0;
                end else if (!hold[k]) begin
                    if (bubble[k]) begin
                        data_q[k*DATA_W +: DATA_W] <= '0;
                        valid_q[k]                 <= 1'b0;
                    end else begin
                        data_q[k*DATA_W +: DATA_W] <= i_data[k*DATA_W +: DATA_W];
                        valid_q[k]                 <= prev_valid[k];
                    end
                end
            end
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;

`ifdef PIPE_CHAIN_PERF_EN
    logic [NUM_STAGES*PERF_CNT_W-1:0] stall_cnt;
    logic [NUM_STAGES*PERF_CNT_W-1:0] flush_cnt;

    always_ff @(posedge clk_to_use or posedge i_rst) begin
        if (i_rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (hold[k] && !i_freeze && (stall_cnt[k*PERF_CNT_W +: PERF_CNT_W] != '1)) begin
                    stall_cnt[k*PERF_CNT_W +: PERF_CNT_W] <=
                        stall_cnt[k*PERF_CNT_W +: PERF_CNT_W] + 1'b1;
                end
                if (i_flush[k] && (flush_cnt[k*PERF_CNT_W +: PERF_CNT_W] != '1)) begin
                    flush_cnt[k*PERF_CNT_W +: PERF_CNT_W] <=
                        flush_cnt[k*PERF_CNT_W +: PERF_CNT_W] + 1'b1;
                end
            end
        end
    end
`endif

    pipe_dbg_serializer #(
        .NUM_STAGES (NUM_STAGES),
        .DATA_W     (DATA_W)
    ) u_dbg (
        .clk_to_use (clk_to_use),
        .i_rst      (i_rst),
        .pipe_data  (data_q),
        .pipe_valid (valid_q),
`ifdef PIPE_CHAIN_PERF_EN
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
`endif
        .dbg_req    (i_dbg_req),
        .dbg_ready  (i_dbg_ready),
        .dbg_byte   (o_dbg_byte),
        .dbg_valid  (o_dbg_valid),
        .dbg_busy   (o_dbg_busy)
    );

endmodule
